// File: rtl/trap_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : trap_sequencer_if
//  Description : Bundle of every pipeline / CSR-file / next-PC signal that
//                the machine-mode trap sequencer exchanges. clk and reset_n
//                stay outside as plain ports.
//  Modports    : master - environment side (drives requests, CSR values,
//                         pipeline status and redirect_ready)
//                slave  - the sequencer itself
//  Revision    : 1.0  initial release
// ============================================================================
interface trap_sequencer_if;
    // Requests and status into the sequencer
    logic        exc_valid;
    logic [5:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] irq_pc;
    logic        timer_irq;
    logic        external_irq;
    logic        mstatus_mie;
    logic        mie_mtie;
    logic        mie_meie;
    logic        mret_req;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        pipe_busy;
    logic        redirect_ready;

    // Controls out of the sequencer
    logic        stall_fetch;
    logic        flush;
    logic        trap_take;
    logic        trap_ret;
    logic [5:0]  trap_cause;
    logic        trap_is_irq;
    logic [31:0] trap_epc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drain_timeout;
    logic        busy;

    modport master (
        output exc_valid, exc_code, exc_pc, irq_pc, timer_irq, external_irq,
               mstatus_mie, mie_mtie, mie_meie, mret_req, mtvec, mepc,
               pipe_busy, redirect_ready,
        input  stall_fetch, flush, trap_take, trap_ret, trap_cause,
               trap_is_irq, trap_epc, redirect_valid, redirect_pc,
               drain_timeout, busy
    );

    modport slave (
        input  exc_valid, exc_code, exc_pc, irq_pc, timer_irq, external_irq,
               mstatus_mie, mie_mtie, mie_meie, mret_req, mtvec, mepc,
               pipe_busy, redirect_ready,
        output stall_fetch, flush, trap_take, trap_ret, trap_cause,
               trap_is_irq, trap_epc, redirect_valid, redirect_pc,
               drain_timeout, busy
    );
endinterface
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : trap_sequencer
//  Description : Machine-mode trap / mret sequencer between the pipeline and
//                the CSR file. Arbitrates exception > external irq > timer
//                irq > mret, stalls fetch, drains the pipeline, strobes the
//                CSR file for one cycle and then redirects the next-PC logic.
//                One trap or return in flight at a time.
//  Ports       : clk      - core clock
//                reset_n  - asynchronous active-low reset
//                bus      - trap_sequencer_if.slave (requests, CSR values,
//                           pipeline status, strobes, latched cause/epc,
//                           redirect handshake, busy/timeout status)
//  Parameters  : DRAIN_TIMEOUT - max cycles in DRAIN before forcing TAKE
//                VECTORED_EN   - allow vectored irq dispatch when mtvec[0]=1
//  Revision    : 1.0  initial release
// ============================================================================
module trap_sequencer #(
    parameter int DRAIN_TIMEOUT = 16,
    parameter bit VECTORED_EN   = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    trap_sequencer_if.slave   bus
);

    localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [5:0]       C_CAUSE_MEI = 6'd11;
    localparam logic [5:0]       C_CAUSE_MTI = 6'd7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_TAKE     = 3'd2,
        S_REDIRECT = 3'd3,
        S_RET      = 3'd4
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [5:0]         cause_q,  cause_d;
    logic               is_irq_q, is_irq_d;
    logic [31:0]        epc_q,    epc_d;
    // Marks the first RET cycle so trap_ret/flush fire only once even while
    // the redirect is back-pressured.
    logic               ret_first_q, ret_first_d;

    logic               w_ext_take;
    logic               w_tmr_take;
    logic               w_drain_last;
    logic [31:0]        w_tvec_base;
    logic [31:0]        w_vec_offset;
    logic               w_vectored;

    // Interrupt enables only matter here, so they are effectively sampled in
    // IDLE; an irq held high after the CSR file clears MIE cannot re-trigger.
    assign w_ext_take   = bus.mstatus_mie & bus.mie_meie & bus.external_irq;
    assign w_tmr_take   = bus.mstatus_mie & bus.mie_mtie & bus.timer_irq;
    assign w_drain_last = (cnt_q == C_CNT_LAST);

    // Exceptions always land on the base; only interrupts may be vectored.
    assign w_tvec_base  = {bus.mtvec[31:2], 2'b00};
    assign w_vec_offset = {24'd0, cause_q, 2'b00};
    assign w_vectored   = VECTORED_EN & bus.mtvec[0] & is_irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cause_q     <= '0;
            is_irq_q    <= 1'b0;
            epc_q       <= '0;
            ret_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            is_irq_q    <= is_irq_d;
            epc_q       <= epc_d;
            ret_first_q <= ret_first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        is_irq_d    = is_irq_q;
        epc_d       = epc_q;
        ret_first_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // An exception alongside mret wins; the mret is flushed.
                if (bus.exc_valid) begin
                    cause_d  = bus.exc_code;
                    epc_d    = bus.exc_pc;
                    is_irq_d = 1'b0;
                    state_d  = S_DRAIN;
                end else if (w_ext_take) begin
                    cause_d  = C_CAUSE_MEI;
                    epc_d    = bus.irq_pc;
                    is_irq_d = 1'b1;
                    state_d  = S_DRAIN;
                end else if (w_tmr_take) begin
                    cause_d  = C_CAUSE_MTI;
                    epc_d    = bus.irq_pc;
                    is_irq_d = 1'b1;
                    state_d  = S_DRAIN;
                end else if (bus.mret_req) begin
                    ret_first_d = 1'b1;
                    state_d     = S_RET;
                end
            end
            S_DRAIN: begin
                if (!bus.pipe_busy || w_drain_last) begin
                    state_d = S_TAKE;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            S_TAKE: begin
                state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_RET: begin
                if (bus.redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode from the registered state, so an asynchronous reset
    // clears them immediately.
    always_comb begin
        bus.stall_fetch    = 1'b0;
        bus.flush          = 1'b0;
        bus.trap_take      = 1'b0;
        bus.trap_ret       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.drain_timeout  = 1'b0;
        bus.busy           = 1'b0;

        case (state_q)
            S_DRAIN: begin
                bus.stall_fetch   = 1'b1;
                bus.busy          = 1'b1;
                // Pulse only when the timeout, not an idle pipe, ends DRAIN.
                bus.drain_timeout = w_drain_last & bus.pipe_busy;
            end
            S_TAKE: begin
                bus.stall_fetch = 1'b1;
                bus.busy        = 1'b1;
                bus.trap_take   = 1'b1;
                bus.flush       = 1'b1;
            end
            S_REDIRECT: begin
                bus.stall_fetch    = 1'b1;
                bus.busy           = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = w_vectored ? (w_tvec_base + w_vec_offset)
                                                : w_tvec_base;
            end
            S_RET: begin
                bus.stall_fetch    = 1'b1;
                bus.busy           = 1'b1;
                bus.trap_ret       = ret_first_q;
                bus.flush          = ret_first_q;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = {bus.mepc[31:2], 2'b00};
            end
            default: begin
            end
        endcase
    end

    assign bus.trap_cause  = cause_q;
    assign bus.trap_is_irq = is_irq_q;
    assign bus.trap_epc    = epc_q;

    // Low address bits are architecturally ignored for both targets.
    logic w_unused_bits;
    assign w_unused_bits = bus.mtvec[1] ^ bus.mepc[1] ^ bus.mepc[0];

endmodule
`default_nettype wire
